// File: rtl/output_word_packer.sv
// ============================================================================
// Module   : output_word_packer
// Purpose  : Packs a serial stream of convolution result bits into 16-bit
//            SRAM words. Bit k of each word is the (k+1)th accepted bit of
//            that word, so bit 0 is filled first. Words go to consecutive
//            addresses starting at base_addr. A partial final word is padded
//            with zeros in its upper bits.
// Option   : PACKER_HEADER_EN - when defined, a one-cycle HEADER state writes
//            {7'b0, total_bits} at base_addr and data words start at
//            base_addr+1.
// Ports    : clk, reset_b (async, active low)
//            start, base_addr[11:0], total_bits[8:0]  - job request
//            bit_valid, bit_data, bit_ready           - bit stream handshake
//            busy, done                               - job status
//            dut_sram_write_enable/_address[11:0]/_data[15:0] - SRAM port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_word_packer (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        start,
  input  logic [11:0] base_addr,
  input  logic [8:0]  total_bits,
  input  logic        bit_valid,
  input  logic        bit_data,
  output logic        bit_ready,
  output logic        busy,
  output logic        done,
  output logic        dut_sram_write_enable,
  output logic [11:0] dut_sram_write_address,
  output logic [15:0] dut_sram_write_data
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [8:0]  r_total;     // clamped bit count of the current job
  logic [8:0]  r_count;     // bits accepted so far in this job
  logic [3:0]  r_bitpos;    // position of the next bit inside the current word
  logic [15:0] r_shreg;     // partially assembled word
  logic [11:0] r_ptr;       // address of the next data word
  logic        r_we;
  logic [11:0] r_addr;
  logic [15:0] r_data;

  logic        w_start_ok;
  logic        w_accept;
  logic [8:0]  w_count_inc;
  logic        w_last;
  logic        w_word_full;
  logic [15:0] w_word;
  logic [8:0]  w_clamped;

  // Any request above 256 has bit 8 set together with some lower bit;
  // exactly 256 also has bit 8 set, so bit 8 alone selects the clamp value.
  assign w_clamped   = total_bits[8] ? 9'd256 : total_bits;
  assign w_start_ok  = start && (r_state == ST_IDLE);
  assign w_accept    = bit_valid && (r_state == ST_COLLECT);
  assign w_count_inc = r_count + 9'd1;
  assign w_last      = w_accept && (w_count_inc == r_total);
  assign w_word_full = w_accept && (r_bitpos == 4'd15);
  // Current word with the incoming bit merged in at its slot.
  assign w_word      = r_shreg | ({15'b0, bit_data} << r_bitpos);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef PACKER_HEADER_EN
          w_state_next = ST_HEADER;
`else
          w_state_next = (w_clamped == 9'd0) ? ST_DONE : ST_COLLECT;
`endif
        end
      end
      ST_HEADER: begin
        w_state_next = (r_total == 9'd0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_last) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: bit assembly, address pointer and registered SRAM strobe.
  // The final word is registered on the last accept, so it is presented
  // during the FLUSH cycle. When that last bit also completes a full word the
  // single write covers both cases, so no duplicate is produced.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_total  <= 9'd0;
      r_count  <= 9'd0;
      r_bitpos <= 4'd0;
      r_shreg  <= 16'd0;
      r_ptr    <= 12'd0;
      r_we     <= 1'b0;
      r_addr   <= 12'd0;
      r_data   <= 16'd0;
    end else begin
      r_we <= 1'b0;

      if (w_start_ok) begin
        r_total  <= w_clamped;
        r_count  <= 9'd0;
        r_bitpos <= 4'd0;
        r_shreg  <= 16'd0;
`ifdef PACKER_HEADER_EN
        // Header write is presented during the HEADER cycle itself.
        r_we     <= 1'b1;
        r_addr   <= base_addr;
        r_data   <= {7'b0, w_clamped};
        r_ptr    <= base_addr + 12'd1;
`else
        r_ptr    <= base_addr;
`endif
      end

      if (w_accept) begin
        r_count <= w_count_inc;
        if (w_word_full || w_last) begin
          r_we     <= 1'b1;
          r_addr   <= r_ptr;
          r_data   <= w_word;
          r_ptr    <= r_ptr + 12'd1;   // wraps 0xFFF -> 0x000
          r_shreg  <= 16'd0;
          r_bitpos <= 4'd0;
        end else begin
          r_shreg  <= w_word;
          r_bitpos <= r_bitpos + 4'd1;
        end
      end
    end
  end

  assign bit_ready              = (r_state == ST_COLLECT);
  assign busy                   = (r_state != ST_IDLE);
  assign done                   = (r_state == ST_DONE);
  assign dut_sram_write_enable  = r_we;
  assign dut_sram_write_address = r_addr;
  assign dut_sram_write_data    = r_data;

endmodule

`default_nettype wire

// File: tb/tb_output_word_packer.sv
// ============================================================================
// Module   : tb_output_word_packer
// Purpose  : Directed self-checking bench for output_word_packer. Inputs are
//            driven 1 time unit after each rising edge and outputs are
//            sampled in that same window, well away from the next edge.
//            Expected SRAM words are rebuilt bit by bit from the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_word_packer;

  logic        clk;
  logic        reset_b;
  logic        start;
  logic [11:0] base_addr;
  logic [8:0]  total_bits;
  logic        bit_valid;
  logic        bit_data;
  logic        bit_ready;
  logic        busy;
  logic        done;
  logic        dut_sram_write_enable;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;

  int checks   = 0;
  int failures = 0;

`ifdef PACKER_HEADER_EN
  localparam logic [11:0] HDR = 12'd1;
`else
  localparam logic [11:0] HDR = 12'd0;
`endif

  output_word_packer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .start                  (start),
    .base_addr              (base_addr),
    .total_bits             (total_bits),
    .bit_valid              (bit_valid),
    .bit_data               (bit_data),
    .bit_ready              (bit_ready),
    .busy                   (busy),
    .done                   (done),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start; a stray valid bit is offered during start (and header) to
  // show that bits outside COLLECT are ignored.
  task automatic do_start(input logic [11:0] b, input logic [8:0] t);
    logic [8:0] cl;
    cl = (t > 9'd256) ? 9'd256 : t;
    start      = 1'b1;
    base_addr  = b;
    total_bits = t;
    bit_valid  = 1'b1;
    bit_data   = 1'b0;
    chk("idle_busy", busy, 0);
    cyc();
    start      = 1'b0;
    base_addr  = 12'h5A5;
    total_bits = 9'h0AA;
    chk("start_busy", busy, 1);
`ifdef PACKER_HEADER_EN
    chk("hdr_we", dut_sram_write_enable, 1);
    chk("hdr_addr", dut_sram_write_address, b);
    chk("hdr_data", dut_sram_write_data, {23'b0, cl});
    chk("hdr_ready", bit_ready, 0);
    cyc();
`endif
    bit_valid = 1'b0;
  endtask

  // Stream n bits (bit i = pat[i%32]); check every cycle for the exact write
  // pattern. At index restart_at an extra start with other parameters is
  // applied, which must be ignored.
  task automatic feed(input logic [11:0] addr0, input int n, input logic [31:0] pat,
                      input int restart_at);
    logic [11:0] ea;
    logic [15:0] ew;
    ea = addr0;
    ew = 16'd0;
    for (int i = 0; i < n; i++) begin
      chk("ready", bit_ready, 1);
      bit_valid = 1'b1;
      bit_data  = pat[i % 32];
      if (i == restart_at) begin
        start      = 1'b1;
        base_addr  = 12'hABC;
        total_bits = 9'd1;
      end
      ew[i % 16] = bit_data;
      cyc();
      start = 1'b0;
      if ((i % 16) == 15 || i == n - 1) begin
        chk("word_we", dut_sram_write_enable, 1);
        chk("word_addr", dut_sram_write_address, ea);
        chk("word_data", dut_sram_write_data, ew);
        ea = ea + 12'd1;
        ew = 16'd0;
      end else begin
        chk("gap_we", dut_sram_write_enable, 0);
      end
    end
    bit_valid = 1'b0;
  endtask

  // Called in the FLUSH cycle: expect DONE next, then IDLE.
  task automatic finish_job();
    chk("flush_ready", bit_ready, 0);
    bit_valid = 1'b1;
    bit_data  = 1'b1;
    cyc();
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_we", dut_sram_write_enable, 0);
    bit_valid = 1'b0;
    cyc();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_ready", bit_ready, 0);
  endtask

  initial begin
    reset_b    = 1'b0;
    start      = 1'b0;
    base_addr  = 12'd0;
    total_bits = 9'd0;
    bit_valid  = 1'b0;
    bit_data   = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", bit_ready, 0);
    chk("rst_we", dut_sram_write_enable, 0);
    chk("rst_addr", dut_sram_write_address, 0);
    chk("rst_data", dut_sram_write_data, 0);
    reset_b = 1'b1;
    cyc();

    // One full word of alternating bits.
    do_start(12'h100, 9'd16);
    feed(12'h100 + HDR, 16, 32'h5555_5555, -1);
    finish_job();

    // 20 ones: full word then a 4-bit flush word; ignored start mid-stream.
    do_start(12'h100, 9'd20);
    feed(12'h100 + HDR, 20, 32'hFFFF_FFFF, 5);
    finish_job();

    // Zero-length job: no data writes, done straight after start/header.
    do_start(12'h050, 9'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_we", dut_sram_write_enable, 0);
    chk("zero_ready", bit_ready, 0);
    cyc();
    chk("zero_after_busy", busy, 0);
    chk("zero_after_done", done, 0);

    // Address wrap 0xFFF -> 0x000.
    do_start(12'hFFF, 9'd32);
    feed(12'hFFF + HDR, 32, 32'h1234_ABCD, -1);
    finish_job();

    // Nine bits (header case writes 0x0009 first).
    do_start(12'h200, 9'd9);
    feed(12'h200 + HDR, 9, 32'h0000_0135, -1);
    finish_job();

    // Oversized request clamps to 256 bits = 16 words.
    do_start(12'h010, 9'd300);
    feed(12'h010 + HDR, 256, 32'hC3A5_0F1E, -1);
    finish_job();

    // Reset after 8 accepted bits abandons the job.
    do_start(12'h300, 9'd16);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'b1;
      cyc();
      chk("pre_rst_we", dut_sram_write_enable, 0);
    end
    #2;
    reset_b = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", bit_ready, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_we", dut_sram_write_enable, 0);
    chk("async_rst_addr", dut_sram_write_address, 0);
    chk("async_rst_data", dut_sram_write_data, 0);
    cyc();
    cyc();
    reset_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("post_rst_we", dut_sram_write_enable, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    bit_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
